// File: rtl/period_energy_detector_pkg.sv
// Shared definitions for the period energy detector: datapath width,
// saturation ceiling and the debounce/hold FSM state encoding.
package period_energy_detector_pkg;

   localparam int SUM_W = 32;
   localparam logic [SUM_W-1:0] SUM_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMING,
      ST_DETECTED,
      ST_HOLD
   } det_state_t;

endpackage

// File: rtl/period_energy_detector_window_accumulator.sv
// Window accumulator: clamps negative period sums to zero, adds them with
// saturation over 2^WIN_LOG2 valid periods and publishes the window energy.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          low: partial window discarded, win_valid held low
//   sum_valid       abs_sum carries one period result
//   abs_sum         signed period absolute sum
//   win_valid       one-cycle strobe, win_energy just updated
//   win_energy      saturated energy of the last completed window
module window_accumulator
   import period_energy_detector_pkg::*;
#(
   parameter int WIN_LOG2 = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             sum_valid,
   input  logic [SUM_W-1:0] abs_sum,
   output logic             win_valid,
   output logic [SUM_W-1:0] win_energy
);

   logic [SUM_W-1:0]    acc;
   logic [WIN_LOG2-1:0] per_cnt;
   logic [SUM_W-1:0]    sample;
   logic [SUM_W:0]      sum_ext;
   logic [SUM_W-1:0]    sum_sat;
   logic                last_period;

   always_comb begin
      sample      = abs_sum[SUM_W-1] ? '0 : abs_sum;
      sum_ext     = {1'b0, acc} + {1'b0, sample};
      // carry out of the 32-bit add means the true sum exceeded the ceiling
      sum_sat     = sum_ext[SUM_W] ? SUM_MAX : sum_ext[SUM_W-1:0];
      last_period = &per_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         per_cnt    <= '0;
         win_valid  <= 1'b0;
         win_energy <= '0;
      end else if (!enable) begin
         acc       <= '0;
         per_cnt   <= '0;
         win_valid <= 1'b0;
      end else begin
         win_valid <= 1'b0;
         if (sum_valid) begin
            per_cnt <= per_cnt + WIN_LOG2'(1);
            if (last_period) begin
               acc        <= '0;
               win_energy <= sum_sat;
               win_valid  <= 1'b1;
            end else begin
               acc <= sum_sat;
            end
         end
      end
   end

endmodule

// File: rtl/period_energy_detector.sv
// Period energy detector: accumulates period sums into window energies,
// compares each window against a threshold and debounces the result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          low: block idle, detect/strobes forced low
//   sum_valid       abs_sum carries one period result
//   abs_sum         signed period absolute sum
//   threshold       window energy threshold (hit when energy > threshold)
//   win_valid       one-cycle strobe, win_energy updated
//   win_energy      saturated energy of the last completed window
//   detect          high while DETECTED or HOLD
//   detect_pulse    one-cycle strobe on entry to DETECTED from IDLE/ARMING
//
// state       | meaning
// ST_IDLE     | no recent hit
// ST_ARMING   | counting consecutive hit windows toward HIT_CNT
// ST_DETECTED | detection declared, last window was a hit
// ST_HOLD     | detection held, counting consecutive misses toward HOLD_CNT
module period_energy_detector
   import period_energy_detector_pkg::*;
#(
   parameter int WIN_LOG2 = 3,
   parameter int HIT_CNT  = 4,
   parameter int HOLD_CNT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             sum_valid,
   input  logic [SUM_W-1:0] abs_sum,
   input  logic [SUM_W-1:0] threshold,
   output logic             win_valid,
   output logic [SUM_W-1:0] win_energy,
   output logic             detect,
   output logic             detect_pulse
);

   localparam logic [3:0] HIT_LAST  = 4'(HIT_CNT);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CNT);

   logic       acc_valid;
   det_state_t state, state_nxt;
   logic [3:0] hit_cnt, hit_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic       pulse_q, pulse_nxt;
   logic       hit;

   window_accumulator #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_acc (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .sum_valid  (sum_valid),
      .abs_sum    (abs_sum),
      .win_valid  (acc_valid),
      .win_energy (win_energy)
   );

   // threshold is compared live in the win_valid cycle
   assign hit = win_energy > threshold;

   always_comb begin
      state_nxt = state;
      hit_nxt   = hit_cnt;
      hold_nxt  = hold_cnt;
      pulse_nxt = 1'b0;
      if (acc_valid) begin
         unique case (state)
            ST_IDLE: begin
               if (hit) begin
                  if (HIT_LAST == 4'd1) begin
                     state_nxt = ST_DETECTED;
                     hit_nxt   = '0;
                     pulse_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_ARMING;
                     hit_nxt   = 4'd1;
                  end
               end
            end
            ST_ARMING: begin
               if (!hit) begin
                  state_nxt = ST_IDLE;
                  hit_nxt   = '0;
               end else if (hit_cnt + 4'd1 == HIT_LAST) begin
                  state_nxt = ST_DETECTED;
                  hit_nxt   = '0;
                  pulse_nxt = 1'b1;
               end else begin
                  hit_nxt = hit_cnt + 4'd1;
               end
            end
            ST_DETECTED: begin
               if (!hit) begin
                  if (HOLD_LAST == 8'd1) begin
                     state_nxt = ST_IDLE;
                     hold_nxt  = '0;
                  end else begin
                     state_nxt = ST_HOLD;
                     hold_nxt  = 8'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (hit) begin
                  state_nxt = ST_DETECTED;
                  hold_nxt  = '0;
               end else if (hold_cnt + 8'd1 == HOLD_LAST) begin
                  state_nxt = ST_IDLE;
                  hold_nxt  = '0;
               end else begin
                  hold_nxt = hold_cnt + 8'd1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               hit_nxt   = '0;
               hold_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state    <= ST_IDLE;
         hit_cnt  <= '0;
         hold_cnt <= '0;
         pulse_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hit_cnt  <= hit_nxt;
         hold_cnt <= hold_nxt;
         pulse_q  <= pulse_nxt;
      end
   end

   // enable low must silence the outputs in the same cycle, not one later
   assign win_valid    = acc_valid & enable;
   assign detect_pulse = pulse_q & enable;
   assign detect       = enable & ((state == ST_DETECTED) || (state == ST_HOLD));

endmodule
